// File: rtl/led_status_ctrl.sv
// LED status controller: packs mode, minigame and heartbeat onto an LED bar
// with PWM dimming, plus an alarm override with animated patterns.
//
// Ports:
//   MCLK          system clock (sole clock)
//   RESET_N       synchronous active-low reset
//   MODE          mode indicator, shown on the top MODE_W LEDs
//   minigame      minigame status, shown on the next GAME_W LEDs
//   alarm_ringing level; high selects the alarm pattern override
//   alarm_pattern 0 BLINK, 1 CHASE, 2 ALT, 3 BLINK (latched on alarm entry)
//   brightness    normal-frame PWM duty (0 off, all-ones fully on)
//   LED           registered LED drive
module led_status_ctrl #(
    parameter int N_LED    = 16,
    parameter int MODE_W   = 4,
    parameter int GAME_W   = 10,
    parameter int TICK_DIV = 25_000_000,
    parameter int PWM_W    = 4
) (
    input  logic              MCLK,
    input  logic              RESET_N,
    input  logic [MODE_W-1:0] MODE,
    input  logic [GAME_W-1:0] minigame,
    input  logic              alarm_ringing,
    input  logic [1:0]        alarm_pattern,
    input  logic [PWM_W-1:0]  brightness,
    output logic [N_LED-1:0]  LED
);

    localparam int HB_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [HB_W-1:0] TICK_MAX = HB_W'(TICK_DIV - 1);
    localparam int PAD_W = N_LED - MODE_W - GAME_W - 1;

    typedef enum logic {
        S_IDLE,
        S_ALARM
    } state_e;

    typedef enum logic [1:0] {
        PAT_BLINK,
        PAT_CHASE,
        PAT_ALT
    } pat_e;

    state_e            state_q, state_d;
    pat_e              pat_q, pat_d, pat_sel;
    logic [HB_W-1:0]   hb_cnt_q, hb_cnt_d;
    logic              heartbeat_q, heartbeat_d;
    logic [HB_W-1:0]   alm_cnt_q, alm_cnt_d;
    logic [PWM_W-1:0]  pwm_cnt_q, pwm_cnt_d;
    logic [N_LED-1:0]  led_q, led_d;

    logic              en;
    logic [N_LED-1:0]  frame;
    logic [N_LED-1:0]  alt_init;
    logic [N_LED-1:0]  init_pat;

    // Free-running prescaler and PWM counter, independent of the alarm.
    always_comb begin
        hb_cnt_d    = hb_cnt_q + HB_W'(1);
        heartbeat_d = heartbeat_q;
        if (hb_cnt_q == TICK_MAX) begin
            hb_cnt_d    = '0;
            heartbeat_d = ~heartbeat_q;
        end
        pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
    end

    assign en    = (&brightness) || (pwm_cnt_q < brightness);
    assign frame = {MODE, minigame, {PAD_W{1'b0}}, heartbeat_q}
                 & {N_LED{en}};

    always_comb begin
        alt_init = '0;
        for (int i = 0; i < N_LED; i++) begin
            alt_init[i] = ((i % 2) == 0);
        end
    end

    always_comb begin
        unique case (alarm_pattern)
            2'd1:    pat_sel = PAT_CHASE;
            2'd2:    pat_sel = PAT_ALT;
            default: pat_sel = PAT_BLINK;
        endcase
    end

    always_comb begin
        unique case (pat_sel)
            PAT_CHASE: init_pat = {{(N_LED-1){1'b0}}, 1'b1};
            PAT_ALT:   init_pat = alt_init;
            default:   init_pat = '1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        alm_cnt_d = alm_cnt_q;
        led_d     = frame;
        unique case (state_q)
            S_IDLE: begin
                if (alarm_ringing) begin
                    state_d   = S_ALARM;
                    pat_d     = pat_sel;
                    alm_cnt_d = '0;
                    led_d     = init_pat;
                end
            end
            S_ALARM: begin
                if (!alarm_ringing) begin
                    state_d = S_IDLE;
                end else if (alm_cnt_q == TICK_MAX) begin
                    alm_cnt_d = '0;
                    // CHASE rotates; BLINK and ALT both just invert.
                    if (pat_q == PAT_CHASE) begin
                        led_d = {led_q[N_LED-2:0], led_q[N_LED-1]};
                    end else begin
                        led_d = ~led_q;
                    end
                end else begin
                    alm_cnt_d = alm_cnt_q + HB_W'(1);
                    led_d     = led_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge MCLK) begin
        if (!RESET_N) begin
            state_q     <= S_IDLE;
            pat_q       <= PAT_BLINK;
            hb_cnt_q    <= '0;
            heartbeat_q <= 1'b0;
            alm_cnt_q   <= '0;
            pwm_cnt_q   <= '0;
            led_q       <= '0;
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            hb_cnt_q    <= hb_cnt_d;
            heartbeat_q <= heartbeat_d;
            alm_cnt_q   <= alm_cnt_d;
            pwm_cnt_q   <= pwm_cnt_d;
            led_q       <= led_d;
        end
    end

    assign LED = led_q;

endmodule

// File: tb/tb_led_status_ctrl.sv
// Testbench for led_status_ctrl: directed scenarios plus randomized traffic,
// all checked against a time-based reference model.
module tb_led_status_ctrl;

    localparam int T = 4;

    logic        MCLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic [3:0]  MODE = '0;
    logic [9:0]  minigame = '0;
    logic        alarm_ringing = 1'b0;
    logic [1:0]  alarm_pattern = '0;
    logic [3:0]  brightness = '0;
    logic [15:0] LED;

    led_status_ctrl #(
        .N_LED(16), .MODE_W(4), .GAME_W(10), .TICK_DIV(T), .PWM_W(4)
    ) dut (
        .MCLK(MCLK),
        .RESET_N(RESET_N),
        .MODE(MODE),
        .minigame(minigame),
        .alarm_ringing(alarm_ringing),
        .alarm_pattern(alarm_pattern),
        .brightness(brightness),
        .LED(LED)
    );

    always #5 MCLK = ~MCLK;

    int checks = 0;
    int errors = 0;

    // Model: n = clock edges since reset release; alarm entry recorded as
    // an edge index, so pattern step = elapsed edges / T.
    int          n = 0;
    int          ent = 0;
    int          mpat = 0;
    bit          in_alarm = 0;
    logic [15:0] exp_led = '0;

    function automatic logic [15:0] frame_f(int nn);
        bit          hb;
        int          pwm;
        bit          on;
        logic [15:0] f;
        hb  = ((nn / T) % 2) == 1;
        pwm = nn % 16;
        on  = (brightness == 4'hF) || (pwm < int'(brightness));
        f   = {MODE, minigame, 1'b0, hb};
        return on ? f : 16'h0000;
    endfunction

    function automatic logic [15:0] pattern_f(int p, int k);
        logic [15:0] one;
        one = 16'h0001;
        if (p == 1) return one << (k % 16);
        if (p == 2) return ((k % 2) == 0) ? 16'h5555 : 16'hAAAA;
        return ((k % 2) == 0) ? 16'hFFFF : 16'h0000;
    endfunction

    // Advance one clock; the model consumes the inputs present at the edge.
    task automatic tick();
        @(posedge MCLK);
        if (!RESET_N) begin
            exp_led  = 16'h0000;
            in_alarm = 0;
            n        = 0;
        end else begin
            if (!in_alarm) begin
                if (alarm_ringing) begin
                    in_alarm = 1;
                    ent      = n;
                    mpat     = (alarm_pattern == 2'd3) ? 0 : int'(alarm_pattern);
                    exp_led  = pattern_f(mpat, 0);
                end else begin
                    exp_led = frame_f(n);
                end
            end else if (!alarm_ringing) begin
                in_alarm = 0;
                exp_led  = frame_f(n);
            end else begin
                exp_led = pattern_f(mpat, (n - ent) / T);
            end
            n++;
        end
        #1;
    endtask

    task automatic test_reset();
        RESET_N       = 1'b0;
        alarm_ringing = 1'b1;
        alarm_pattern = 2'd0;
        brightness    = 4'hF;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (LED !== 16'h0000) begin
                errors++;
                $display("FAIL reset_led got %h want 0000", LED);
            end
        end
        RESET_N = 1'b1;
        tick();
        checks++;
        if (LED !== 16'hFFFF) begin
            errors++;
            $display("FAIL reset_first_blink got %h want ffff", LED);
        end
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if (LED !== exp_led) begin
                errors++;
                $display("FAIL reset_blink i=%0d got %h want %h", i, LED, exp_led);
            end
        end
    endtask

    task automatic test_normal();
        alarm_ringing = 1'b0;
        MODE          = 4'hA;
        minigame      = 10'h2AA;
        brightness    = 4'hF;
        tick();
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (LED !== exp_led || LED[15:1] !== {4'hA, 10'h2AA, 1'b0}) begin
                errors++;
                $display("FAIL normal_frame i=%0d got %h want %h", i, LED, exp_led);
            end
        end
    endtask

    task automatic test_pwm();
        int highs;
        brightness = 4'd4;
        tick();
        highs = 0;
        for (int i = 0; i < 32; i++) begin
            tick();
            if (LED[15:12] != 4'h0) highs++;
            checks++;
            if (LED !== exp_led) begin
                errors++;
                $display("FAIL pwm4 i=%0d got %h want %h", i, LED, exp_led);
            end
        end
        checks++;
        if (highs != 8) begin
            errors++;
            $display("FAIL pwm4_duty got %0d want 8", highs);
        end
        brightness = 4'd0;
        tick();
        for (int i = 0; i < 16; i++) begin
            tick();
            checks++;
            if (LED !== 16'h0000) begin
                errors++;
                $display("FAIL pwm0 i=%0d got %h want 0000", i, LED);
            end
        end
        brightness = 4'hF;
    endtask

    task automatic test_chase();
        alarm_pattern = 2'd1;
        alarm_ringing = 1'b1;
        tick();
        checks++;
        if (LED !== 16'h0001) begin
            errors++;
            $display("FAIL chase_entry got %h want 0001", LED);
        end
        for (int i = 1; i <= 64; i++) begin
            tick();
            checks++;
            if (LED !== exp_led) begin
                errors++;
                $display("FAIL chase i=%0d got %h want %h", i, LED, exp_led);
            end
            if (i == 60) begin
                checks++;
                if (LED !== 16'h8000) begin
                    errors++;
                    $display("FAIL chase_top got %h want 8000", LED);
                end
            end
        end
        checks++;
        if (LED !== 16'h0001) begin
            errors++;
            $display("FAIL chase_wrap got %h want 0001", LED);
        end
    endtask

    task automatic test_alt();
        alarm_ringing = 1'b0;
        tick();
        alarm_pattern = 2'd2;
        alarm_ringing = 1'b1;
        tick();
        checks++;
        if (LED !== 16'h5555) begin
            errors++;
            $display("FAIL alt_entry got %h want 5555", LED);
        end
        alarm_pattern = 2'd1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            checks++;
            if (LED !== exp_led) begin
                errors++;
                $display("FAIL alt i=%0d got %h want %h", i, LED, exp_led);
            end
        end
        checks++;
        if (LED !== 16'h5555) begin
            errors++;
            $display("FAIL alt_step2 got %h want 5555", LED);
        end
    endtask

    task automatic test_exit_reentry();
        alarm_ringing = 1'b0;
        tick();
        alarm_pattern = 2'd1;
        alarm_ringing = 1'b1;
        tick();
        for (int i = 0; i < 12; i++) tick();
        checks++;
        if (LED !== 16'h0008) begin
            errors++;
            $display("FAIL exit_pre got %h want 0008", LED);
        end
        alarm_ringing = 1'b0;
        tick();
        checks++;
        if (LED !== exp_led || LED[15:1] !== {4'hA, 10'h2AA, 1'b0}) begin
            errors++;
            $display("FAIL exit_frame got %h want %h", LED, exp_led);
        end
        alarm_ringing = 1'b1;
        tick();
        checks++;
        if (LED !== 16'h0001) begin
            errors++;
            $display("FAIL reentry got %h want 0001", LED);
        end
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if (LED !== ((i < 4) ? 16'h0001 : 16'h0002)) begin
                errors++;
                $display("FAIL reentry_step i=%0d got %h", i, LED);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            RESET_N    = ($urandom_range(0, 63) != 0);
            MODE       = 4'($urandom);
            minigame   = 10'($urandom);
            brightness = 4'($urandom);
            if ($urandom_range(0, 15) == 0) alarm_ringing = ~alarm_ringing;
            alarm_pattern = 2'($urandom);
            tick();
            checks++;
            if (LED !== exp_led) begin
                errors++;
                $display("FAIL random i=%0d got %h want %h", i, LED, exp_led);
            end
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_pwm();
        test_chase();
        test_alt();
        test_exit_reentry();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
